spi_slave_reg_ctrl: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 21 ++
 rtl/cs_sync.sv | 38 +++
 rtl/spi_slave_reg_ctrl.sv | 147 ++++++++++++++
 tb/tb_spi_slave_reg_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_reg_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CMD_RD_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_WAIT,
    RD_NEXT
  } spi_ctrl_state_t;

  // Register address increment; wraps 7'h7F -> 7'h00 by truncation.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/cs_sync.sv
// Chip-select synchronizer with fall/rise edge detection.
// A frame already in progress when reset is released is ignored: falls are
// only accepted once CS has been seen high after reset.
module cs_sync (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_CS_n,
  output logic o_Fall,
  output logic o_Rise
);

  logic cs_p0;
  logic cs_p1;
  logic cs_p2;
  logic primed;
  logic armed;

  // Two-flop synchronizer (cs_p0, cs_p1), edge-detect register (cs_p2) and fall arming.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cs_p0  <= 1'b1;
      cs_p1  <= 1'b1;
      cs_p2  <= 1'b1;
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      cs_p0  <= i_CS_n;
      cs_p1  <= cs_p0;
      cs_p2  <= cs_p1;
      primed <= 1'b1;
      armed  <= armed | (primed & cs_p0);
    end
  end

  assign o_Fall = armed & cs_p2 & ~cs_p1;
  assign o_Rise = ~cs_p2 & cs_p1;

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// Command/address/data sequencer between the SPI_Slave byte interface and a
// single-cycle register bus. Bit 7 of the command byte selects read, bits 6:0
// give the start address; bursts auto-increment the address.
module spi_slave_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE    = 8'hEE,
  parameter int         RD_TIMEOUT  = 16
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_SPI_CS_n,
  input  logic              i_RX_DV,
  input  logic [DATA_W-1:0] i_RX_Byte,
  output logic              o_TX_DV,
  output logic [DATA_W-1:0] o_TX_Byte,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic              o_Reg_Wr_En,
  output logic [DATA_W-1:0] o_Reg_Wr_Data,
  output logic              o_Reg_Rd_En,
  input  logic [DATA_W-1:0] i_Reg_Rd_Data,
  input  logic              i_Reg_Rd_Valid,
  output logic              o_Busy,
  output logic              o_Err
);

  localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT);

  logic cs_fall;
  logic cs_rise;

  spi_ctrl_state_t  state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              tx_dv_d;
  logic [DATA_W-1:0] tx_byte_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_en_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              rd_en_d;
  logic              err_d;

  cs_sync u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_CS_n  (i_SPI_CS_n),
    .o_Fall  (cs_fall),
    .o_Rise  (cs_rise)
  );

  // State, read-wait counter and all registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      o_TX_DV       <= 1'b0;
      o_TX_Byte     <= STATUS_BYTE;
      o_Reg_Addr    <= '0;
      o_Reg_Wr_En   <= 1'b0;
      o_Reg_Wr_Data <= '0;
      o_Reg_Rd_En   <= 1'b0;
      o_Busy        <= 1'b0;
      o_Err         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      o_TX_DV       <= tx_dv_d;
      o_TX_Byte     <= tx_byte_d;
      o_Reg_Addr    <= addr_d;
      o_Reg_Wr_En   <= wr_en_d;
      o_Reg_Wr_Data <= wr_data_d;
      o_Reg_Rd_En   <= rd_en_d;
      o_Busy        <= (state_d != IDLE);
      o_Err         <= err_d;
    end
  end

  // Next state and next output values; CS rise overrides everything, then CS fall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == TO_LAST) ? cnt_q : cnt_q + 8'd1;
    tx_dv_d   = 1'b0;
    tx_byte_d = o_TX_Byte;
    addr_d    = o_Reg_Wr_En ? addr_inc(o_Reg_Addr) : o_Reg_Addr;
    wr_en_d   = 1'b0;
    wr_data_d = o_Reg_Wr_Data;
    rd_en_d   = 1'b0;
    err_d     = o_Err;

    if (cs_rise) begin
      state_d = IDLE;
    end else if (cs_fall) begin
      err_d     = 1'b0;
      tx_dv_d   = 1'b1;
      tx_byte_d = STATUS_BYTE;
      state_d   = CMD;
    end else begin
      unique case (state_q)
        CMD: begin
          if (i_RX_DV) begin
            addr_d = i_RX_Byte[ADDR_W-1:0];
            if (i_RX_Byte[CMD_RD_BIT]) begin
              rd_en_d = 1'b1;
              cnt_d   = 8'd0;
              state_d = RD_WAIT;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (i_RX_DV) begin
            wr_en_d   = 1'b1;
            wr_data_d = i_RX_Byte;
          end
        end
        RD_WAIT: begin
          if (i_Reg_Rd_Valid) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = i_Reg_Rd_Data;
            state_d   = RD_NEXT;
          end else if (cnt_q == TO_LAST) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = ERR_BYTE;
            err_d     = 1'b1;
            state_d   = RD_NEXT;
          end
          if (i_RX_DV) begin
            err_d = 1'b1;
          end
        end
        RD_NEXT: begin
          if (i_RX_DV) begin
            addr_d  = addr_inc(o_Reg_Addr);
            rd_en_d = 1'b1;
            cnt_d   = 8'd0;
            state_d = RD_WAIT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed bench for spi_slave_reg_ctrl: table of single-transfer frames plus
// hand-written sequences for bursts, timeout, abort, overrun and reset.
module tb_spi_slave_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int tx_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int tx_cyc = 0, rd_cyc = 0;
  logic [7:0] last_tx = 8'h00;
  logic [6:0] last_wr_addr = 7'h00;
  logic [7:0] last_wr_data = 8'h00;
  logic [6:0] last_rd_addr = 7'h00;

  typedef struct {
    bit         rd;
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [6:0] addr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  spi_slave_reg_ctrl #(
    .STATUS_BYTE (8'hA5),
    .ERR_BYTE    (8'hEE),
    .RD_TIMEOUT  (16)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_SPI_CS_n     (cs_n),
    .i_RX_DV        (rx_dv),
    .i_RX_Byte      (rx_byte),
    .o_TX_DV        (tx_dv),
    .o_TX_Byte      (tx_byte),
    .o_Reg_Addr     (reg_addr),
    .o_Reg_Wr_En    (wr_en),
    .o_Reg_Wr_Data  (wr_data),
    .o_Reg_Rd_En    (rd_en),
    .i_Reg_Rd_Data  (rd_data),
    .i_Reg_Rd_Valid (rd_valid),
    .o_Busy         (busy),
    .o_Err          (err)
  );

  // Strobe monitor: values seen at a rising edge belong to the cycle it closes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_dv) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= tx_byte;
      tx_cyc  <= cyc;
    end
    if (wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= reg_addr;
      last_wr_data <= wr_data;
    end
    if (rd_en) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= reg_addr;
      rd_cyc       <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    idle(2);
    chk("start_early_tx_dv", 32'(tx_dv), 32'd0);
    idle(1);
    chk("start_tx_dv", 32'(tx_dv), 32'd1);
    chk("start_tx_byte", 32'(tx_byte), 32'hA5);
    chk("start_busy", 32'(busy), 32'd1);
    idle(2);
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    idle(4);
  endtask

  task automatic rd_respond(input logic [7:0] d, input int dly);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_en) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rd_en_seen", 32'(seen), 32'd1);
    if (seen) begin
      repeat (dly) @(negedge clk);
      rd_data  = d;
      rd_valid = 1'b1;
      @(negedge clk);
      rd_valid = 1'b0;
    end
  endtask

  initial begin
    int wc, tc, rc;
    bit got;

    vecs[0] = '{rd: 1'b0, cmd: 8'h05, dat: 8'h5A, addr: 7'h05};
    vecs[1] = '{rd: 1'b0, cmd: 8'h7F, dat: 8'hC3, addr: 7'h7F};
    vecs[2] = '{rd: 1'b1, cmd: 8'h80, dat: 8'h96, addr: 7'h00};
    vecs[3] = '{rd: 1'b1, cmd: 8'hA2, dat: 8'h01, addr: 7'h22};
    vecs[4] = '{rd: 1'b0, cmd: 8'h00, dat: 8'hFF, addr: 7'h00};
    vecs[5] = '{rd: 1'b1, cmd: 8'hFF, dat: 8'h7E, addr: 7'h7F};

    rst_n    = 1'b0;
    cs_n     = 1'b1;
    rx_dv    = 1'b0;
    rx_byte  = 8'h00;
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    idle(3);

    chk("rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'hA5);
    chk("rst_addr", 32'(reg_addr), 32'h00);
    chk("rst_wr_data", 32'(wr_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Table of single-transfer frames.
    for (int v = 0; v < 6; v++) begin
      start_frame();
      if (!vecs[v].rd) begin
        send_byte(vecs[v].cmd);
        idle(3);
        wc = wr_cnt;
        send_byte(vecs[v].dat);
        idle(2);
        chk("vec_wr_cnt", 32'(wr_cnt), 32'(wc + 1));
        chk("vec_wr_addr", 32'(last_wr_addr), 32'(vecs[v].addr));
        chk("vec_wr_data", 32'(last_wr_data), 32'(vecs[v].dat));
      end else begin
        send_byte(vecs[v].cmd);
        rd_respond(vecs[v].dat, 3);
        idle(2);
        chk("vec_rd_addr", 32'(last_rd_addr), 32'(vecs[v].addr));
        chk("vec_rd_tx", 32'(last_tx), 32'(vecs[v].dat));
        chk("vec_rd_err", 32'(err), 32'd0);
      end
      end_frame();
    end

    // Burst write: 10, 3C, 5D.
    start_frame();
    wc = wr_cnt;
    send_byte(8'h10);
    idle(3);
    send_byte(8'h3C);
    idle(2);
    chk("bw_addr0", 32'(last_wr_addr), 32'h10);
    chk("bw_data0", 32'(last_wr_data), 32'h3C);
    idle(1);
    send_byte(8'h5D);
    idle(2);
    chk("bw_addr1", 32'(last_wr_addr), 32'h11);
    chk("bw_data1", 32'(last_wr_data), 32'h5D);
    chk("bw_addr_after", 32'(reg_addr), 32'h12);
    chk("bw_count", 32'(wr_cnt), 32'(wc + 2));
    end_frame();

    // Burst read with address wrap 7F -> 00.
    start_frame();
    send_byte(8'hFF);
    rd_respond(8'h11, 3);
    idle(2);
    chk("br_addr0", 32'(last_rd_addr), 32'h7F);
    chk("br_tx0", 32'(last_tx), 32'h11);
    send_byte(8'h00);
    rd_respond(8'h22, 3);
    idle(2);
    chk("br_addr1", 32'(last_rd_addr), 32'h00);
    chk("br_tx1", 32'(last_tx), 32'h22);
    chk("br_err", 32'(err), 32'd0);
    end_frame();

    // Read timeout.
    start_frame();
    tc = tx_cnt;
    send_byte(8'h85);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_cnt != tc) begin
        got = 1'b1;
        break;
      end
    end
    chk("to_seen", 32'(got), 32'd1);
    chk("to_latency", 32'(tx_cyc - rd_cyc), 32'd17);
    chk("to_byte", 32'(last_tx), 32'hEE);
    chk("to_rd_addr", 32'(last_rd_addr), 32'h05);
    idle(1);
    chk("to_err", 32'(err), 32'd1);
    end_frame();
    chk("to_err_sticky", 32'(err), 32'd1);
    start_frame();
    chk("to_err_cleared", 32'(err), 32'd0);
    end_frame();

    // Abort: CS rises during RD_WAIT, late valid is ignored.
    start_frame();
    send_byte(8'hC0);
    idle(2);
    tc = tx_cnt;
    cs_n = 1'b1;
    idle(3);
    chk("ab_busy_now", 32'(busy), 32'd0);
    idle(1);
    rd_data  = 8'h99;
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    idle(20);
    chk("ab_no_tx", 32'(tx_cnt), 32'(tc));
    chk("ab_busy", 32'(busy), 32'd0);

    // Overrun: dummy byte during RD_WAIT.
    start_frame();
    send_byte(8'h90);
    idle(1);
    rc = rd_cnt;
    send_byte(8'h00);
    idle(2);
    chk("ov_err", 32'(err), 32'd1);
    chk("ov_no_rd", 32'(rd_cnt), 32'(rc));
    chk("ov_busy", 32'(busy), 32'd1);
    rd_data  = 8'h4B;
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    idle(2);
    chk("ov_tx", 32'(last_tx), 32'h4B);
    end_frame();

    // RX byte in the same cycle the CS rise is detected.
    start_frame();
    send_byte(8'h20);
    idle(3);
    wc = wr_cnt;
    cs_n = 1'b1;
    idle(2);
    send_byte(8'h77);
    idle(2);
    chk("sim_no_wr", 32'(wr_cnt), 32'(wc));
    chk("sim_busy", 32'(busy), 32'd0);
    idle(2);

    // Reset in the middle of a write frame.
    start_frame();
    send_byte(8'h30);
    idle(3);
    send_byte(8'h44);
    rst_n = 1'b0;
    #1;
    chk("mr_wr_en", 32'(wr_en), 32'd0);
    chk("mr_tx_byte", 32'(tx_byte), 32'hA5);
    chk("mr_addr", 32'(reg_addr), 32'h00);
    chk("mr_wr_data", 32'(wr_data), 32'h00);
    chk("mr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    wc = wr_cnt;
    tc = tx_cnt;
    send_byte(8'h55);
    idle(3);
    chk("mr_no_wr", 32'(wr_cnt), 32'(wc));
    chk("mr_no_tx", 32'(tx_cnt), 32'(tc));
    chk("mr_idle", 32'(busy), 32'd0);
    end_frame();
    start_frame();
    send_byte(8'h31);
    idle(3);
    send_byte(8'h66);
    idle(2);
    chk("mr_fresh_addr", 32'(last_wr_addr), 32'h31);
    chk("mr_fresh_data", 32'(last_wr_data), 32'h66);
    end_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
